// File: rtl/dbus_lsu.sv
// dbus_lsu: single-outstanding RV32 load/store/LR/SC adapter feeding the shared data-bus arbiter.
// Defining DBUS_LSU_ATOMIC_EN enables the LR/SC qualifiers and SC result return.
`timescale 1ns/1ps
module dbus_lsu (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic        req_lr_i,
    input  logic        req_sc_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        dbus_re_o,
    output logic        dbus_we_o,
    output logic [31:0] dbus_addr_o,
    output logic [31:0] dbus_wdata_o,
    output logic [3:0]  dbus_wstrb_o,
    output logic        dbus_is_lr_o,
    output logic        dbus_is_sc_o,
    input  logic [31:0] dbus_rdata_i,
    input  logic        dbus_stall_i
);
    typedef enum logic [2:0] {IDLE, ISSUE, ACK, BUSY, RESP} state_t;

    // Request handshake: a request transfers on a cycle where req_valid_i && req_ready_o.
    state_t      state;
    logic        we_q;
    logic        sc_q;
    logic [2:0]  funct3_q;
    logic [1:0]  offset_q;
    logic        lr_req;
    logic        sc_req;
    logic        illegal;
    logic [3:0]  strb;
    logic [31:0] wdata_aligned;
    logic [31:0] rdata_shifted;
    logic [31:0] load_data;

`ifdef DBUS_LSU_ATOMIC_EN
    assign lr_req = req_lr_i;
    assign sc_req = req_sc_i;
`else
    logic unused_atomic;
    assign lr_req        = 1'b0;
    assign sc_req        = 1'b0;
    assign unused_atomic = req_lr_i ^ req_sc_i;
`endif

    // The bus is not reset with us, so a stale stall must also hold off new requests.
    assign req_ready_o = (state == IDLE) && !dbus_stall_i;

    always_comb begin
        illegal = 1'b0;
        if (req_addr_i == 32'd0)
            illegal = 1'b1;
        if (req_funct3_i == 3'b011 || req_funct3_i[2:1] == 2'b11)
            illegal = 1'b1;
        if (req_we_i && req_funct3_i[2])
            illegal = 1'b1;
        if (req_funct3_i[1:0] == 2'b01 && req_addr_i[0])
            illegal = 1'b1;
        if (req_funct3_i[1:0] == 2'b10 && req_addr_i[1:0] != 2'b00)
            illegal = 1'b1;
        if ((lr_req || sc_req) && req_funct3_i != 3'b010)
            illegal = 1'b1;
        if ((lr_req && req_we_i) || (sc_req && !req_we_i))
            illegal = 1'b1;
    end

    always_comb begin
        strb = 4'b1111;
        case (req_funct3_i[1:0])
            2'b00:   strb = 4'b0001 << req_addr_i[1:0];
            2'b01:   strb = 4'b0011 << req_addr_i[1:0];
            default: strb = 4'b1111;
        endcase
    end

    assign wdata_aligned = req_wdata_i << {req_addr_i[1:0], 3'b000};
    assign rdata_shifted = dbus_rdata_i >> {offset_q, 3'b000};

    always_comb begin
        load_data = rdata_shifted;
        case (funct3_q)
            3'b000:  load_data = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            3'b001:  load_data = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            3'b100:  load_data = {24'd0, rdata_shifted[7:0]};
            3'b101:  load_data = {16'd0, rdata_shifted[15:0]};
            default: load_data = rdata_shifted;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= IDLE;
            we_q         <= 1'b0;
            sc_q         <= 1'b0;
            funct3_q     <= 3'b000;
            offset_q     <= 2'b00;
            resp_valid_o <= 1'b0;
            resp_rdata_o <= 32'd0;
            resp_err_o   <= 1'b0;
            dbus_re_o    <= 1'b0;
            dbus_we_o    <= 1'b0;
            dbus_addr_o  <= 32'd0;
            dbus_wdata_o <= 32'd0;
            dbus_wstrb_o <= 4'b0000;
            dbus_is_lr_o <= 1'b0;
            dbus_is_sc_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        we_q     <= req_we_i;
                        sc_q     <= sc_req;
                        funct3_q <= req_funct3_i;
                        offset_q <= req_addr_i[1:0];
                        if (illegal) begin
                            resp_valid_o <= 1'b1;
                            resp_err_o   <= 1'b1;
                            resp_rdata_o <= 32'd0;
                            state        <= RESP;
                        end else begin
                            dbus_re_o    <= !req_we_i;
                            dbus_we_o    <= req_we_i;
                            dbus_addr_o  <= req_addr_i;
                            dbus_wdata_o <= req_we_i ? wdata_aligned : 32'd0;
                            dbus_wstrb_o <= req_we_i ? strb : 4'b0000;
                            dbus_is_lr_o <= lr_req;
                            dbus_is_sc_o <= sc_req;
                            state        <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    dbus_re_o    <= 1'b0;
                    dbus_we_o    <= 1'b0;
                    dbus_addr_o  <= 32'd0;
                    dbus_wdata_o <= 32'd0;
                    dbus_wstrb_o <= 4'b0000;
                    dbus_is_lr_o <= 1'b0;
                    dbus_is_sc_o <= 1'b0;
                    state        <= ACK;
                end
                // The bus only raises stall in reaction to the pulse, so skip one cycle before looking.
                ACK: state <= BUSY;
                BUSY: begin
                    if (!dbus_stall_i) begin
                        resp_valid_o <= 1'b1;
                        resp_err_o   <= 1'b0;
                        if (we_q)
                            resp_rdata_o <= sc_q ? {31'd0, dbus_rdata_i[0]} : 32'd0;
                        else
                            resp_rdata_o <= load_data;
                        state <= RESP;
                    end
                end
                RESP: begin
                    resp_valid_o <= 1'b0;
                    resp_err_o   <= 1'b0;
                    resp_rdata_o <= 32'd0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dbus_lsu.sv
// Directed bench for dbus_lsu: driver pushes expected bus pulses and responses, monitors pop and compare.
`timescale 1ns/1ps
module tb_dbus_lsu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        req_lr = 1'b0;
    logic        req_sc = 1'b0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        dbus_re, dbus_we, dbus_is_lr, dbus_is_sc;
    logic [31:0] dbus_addr, dbus_wdata;
    logic [3:0]  dbus_wstrb;
    logic [31:0] dbus_rdata = 32'd0;
    logic        dbus_stall = 1'b0;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
        logic [31:0] cyc;
    } resp_t;
    typedef struct packed {
        logic        re, we, lr, sc;
        logic [3:0]  strb;
        logic [31:0] wdata, addr, cyc;
    } bus_t;

    resp_t exp_q[$];
    bus_t  exp_bus_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    logic [31:0] bus_word = 32'd0;
    int    hold_cfg = 1;
    int    stall_cnt = 0;
    logic  prev_rv = 1'b0;
    logic  prev_pulse = 1'b0;

    dbus_lsu dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_we_i(req_we), .req_funct3_i(req_funct3), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .req_lr_i(req_lr), .req_sc_i(req_sc),
        .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
        .dbus_re_o(dbus_re), .dbus_we_o(dbus_we), .dbus_addr_o(dbus_addr),
        .dbus_wdata_o(dbus_wdata), .dbus_wstrb_o(dbus_wstrb),
        .dbus_is_lr_o(dbus_is_lr), .dbus_is_sc_o(dbus_is_sc),
        .dbus_rdata_i(dbus_rdata), .dbus_stall_i(dbus_stall)
    );

    // Clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus model: unreset, raises stall for hold_cfg cycles after a pulse, returns bus_word.
    always @(posedge clk) begin
        if (dbus_re || dbus_we) begin
            dbus_stall <= (hold_cfg > 0);
            stall_cnt  <= hold_cfg;
            dbus_rdata <= bus_word;
        end else if (stall_cnt > 0) begin
            stall_cnt <= stall_cnt - 1;
            if (stall_cnt == 1) dbus_stall <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor
    always @(negedge clk) begin
        if (rst_n && resp_valid) begin
            chk("resp_pulse_width", {31'd0, prev_rv}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL resp_unexpected: got response 0x%08h err %0b, expected none", resp_rdata, resp_err);
            end else begin
                resp_t e;
                e = exp_q.pop_front();
                chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_cycle", cyc, e.cyc);
            end
        end
        prev_rv <= resp_valid;
    end

    // Bus pulse monitor
    always @(negedge clk) begin
        logic active;
        active = dbus_re | dbus_we | (|dbus_addr) | (|dbus_wdata) | (|dbus_wstrb) | dbus_is_lr | dbus_is_sc;
        if (rst_n && active) begin
            chk("bus_pulse_width", {31'd0, prev_pulse}, 32'd0);
            if (!prev_pulse) begin
                if (exp_bus_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL bus_unexpected: got addr 0x%08h re %0b we %0b, expected no bus activity", dbus_addr, dbus_re, dbus_we);
                end else begin
                    bus_t b;
                    b = exp_bus_q.pop_front();
                    chk("bus_re", {31'd0, dbus_re}, {31'd0, b.re});
                    chk("bus_we", {31'd0, dbus_we}, {31'd0, b.we});
                    chk("bus_is_lr", {31'd0, dbus_is_lr}, {31'd0, b.lr});
                    chk("bus_is_sc", {31'd0, dbus_is_sc}, {31'd0, b.sc});
                    chk("bus_wstrb", {28'd0, dbus_wstrb}, {28'd0, b.strb});
                    chk("bus_wdata", dbus_wdata, b.wdata);
                    chk("bus_addr", dbus_addr, b.addr);
                    chk("bus_cycle", cyc, b.cyc);
                end
            end
        end
        prev_pulse <= rst_n && active;
    end

    // Driver: issue one request and push its expected bus pulse and response.
    task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic lr, input logic sc,
                        input logic [31:0] word, input int hold, input logic exp_err,
                        input logic [31:0] exp_rdata, input logic [3:0] exp_strb,
                        input logic [31:0] exp_wdata, input logic want_resp);
        int n;
        resp_t r;
        bus_t b;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL send_ready_timeout: req_ready stayed 0, expected 1 for addr 0x%08h", addr);
            return;
        end
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        req_lr = lr; req_sc = sc; req_valid = 1'b1;
        bus_word = word; hold_cfg = hold;
        if (want_resp) begin
            r.err   = exp_err;
            r.rdata = exp_rdata;
            r.cyc   = exp_err ? cyc + 1 : cyc + 3 + hold;
            exp_q.push_back(r);
        end
        if (!exp_err) begin
            b.re = !we; b.we = we;
`ifdef DBUS_LSU_ATOMIC_EN
            b.lr = lr; b.sc = sc;
`else
            b.lr = 1'b0; b.sc = 1'b0;
`endif
            b.strb = exp_strb; b.wdata = exp_wdata; b.addr = addr; b.cyc = cyc + 1;
            exp_bus_q.push_back(b);
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_lr = 1'b0;
        req_sc = 1'b0;
    endtask

    initial begin
        int n;
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_dbus_addr", dbus_addr, 32'd0);
        chk("rst_dbus_en", {30'd0, dbus_re, dbus_we}, 32'd0);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        rst_n = 1'b1;

        //   we f3      addr          wdata         lr sc word          hold err rdata         strb     wdata
        send(0, 3'b100, 32'h0000_1003, 32'h0,        0, 0, 32'h80AA55CC, 2,  0, 32'h0000_0080, 4'b0000, 32'h0, 1);
        send(0, 3'b000, 32'h0000_1003, 32'h0,        0, 0, 32'h80AA55CC, 2,  0, 32'hFFFF_FF80, 4'b0000, 32'h0, 1);
        send(1, 3'b001, 32'h0000_2002, 32'h1234ABCD, 0, 0, 32'h0,        3,  0, 32'h0,         4'b1100, 32'hABCD_0000, 1);
        send(0, 3'b010, 32'h0000_3001, 32'h0,        0, 0, 32'h0,        1,  1, 32'h0,         4'b0000, 32'h0, 1);
        send(0, 3'b010, 32'h0000_0000, 32'h0,        0, 0, 32'h0,        1,  1, 32'h0,         4'b0000, 32'h0, 1);
        send(0, 3'b011, 32'h0000_0100, 32'h0,        0, 0, 32'h0,        1,  1, 32'h0,         4'b0000, 32'h0, 1);
        send(0, 3'b111, 32'h0000_0100, 32'h0,        0, 0, 32'h0,        1,  1, 32'h0,         4'b0000, 32'h0, 1);
        send(1, 3'b100, 32'h0000_0100, 32'h0,        0, 0, 32'h0,        1,  1, 32'h0,         4'b0000, 32'h0, 1);
        send(0, 3'b001, 32'h0000_2001, 32'h0,        0, 0, 32'h0,        1,  1, 32'h0,         4'b0000, 32'h0, 1);
        send(0, 3'b001, 32'h0000_2002, 32'h0,        0, 0, 32'h80AA55CC, 1,  0, 32'hFFFF_80AA, 4'b0000, 32'h0, 1);
        send(0, 3'b101, 32'h0000_2002, 32'h0,        0, 0, 32'h80AA55CC, 1,  0, 32'h0000_80AA, 4'b0000, 32'h0, 1);
        send(0, 3'b000, 32'h0000_7002, 32'h0,        0, 0, 32'h80AA55CC, 2,  0, 32'hFFFF_FFAA, 4'b0000, 32'h0, 1);
        send(0, 3'b100, 32'h0000_7001, 32'h0,        0, 0, 32'h80AA55CC, 2,  0, 32'h0000_0055, 4'b0000, 32'h0, 1);
        send(1, 3'b000, 32'h0000_5001, 32'h123456A5, 0, 0, 32'h0,        2,  0, 32'h0,         4'b0010, 32'h3456_A500, 1);
        send(1, 3'b010, 32'h0000_6000, 32'hCAFEF00D, 0, 0, 32'h0,        1,  0, 32'h0,         4'b1111, 32'hCAFE_F00D, 1);

        // Long stall: ready must stay low while the request is in flight.
        send(0, 3'b010, 32'h0000_4000, 32'h0,        0, 0, 32'hDEADBEEF, 20, 0, 32'hDEAD_BEEF, 4'b0000, 32'h0, 1);
        repeat (20) begin
            @(negedge clk);
            chk("ready_low_during_stall", {31'd0, req_ready}, 32'd0);
        end

`ifdef DBUS_LSU_ATOMIC_EN
        send(1, 3'b010, 32'h0000_4000, 32'h1,        0, 1, 32'h00000003, 2,  0, 32'h0000_0001, 4'b1111, 32'h0000_0001, 1);
        send(0, 3'b000, 32'h0000_8000, 32'h0,        1, 0, 32'h0,        1,  1, 32'h0,         4'b0000, 32'h0, 1);
        send(1, 3'b010, 32'h0000_8000, 32'h0,        1, 0, 32'h0,        1,  1, 32'h0,         4'b0000, 32'h0, 1);
        send(0, 3'b010, 32'h0000_8000, 32'h0,        0, 1, 32'h0,        1,  1, 32'h0,         4'b0000, 32'h0, 1);
        send(0, 3'b010, 32'h0000_8000, 32'h0,        1, 0, 32'h11223344, 2,  0, 32'h1122_3344, 4'b0000, 32'h0, 1);
`else
        send(1, 3'b010, 32'h0000_4000, 32'h1,        0, 1, 32'h00000003, 2,  0, 32'h0,         4'b1111, 32'h0000_0001, 1);
        send(0, 3'b000, 32'h0000_8001, 32'h0,        1, 0, 32'h11223344, 2,  0, 32'h0000_0033, 4'b0000, 32'h0, 1);
`endif

        // Reset while BUSY with the bus still stalling.
        send(0, 3'b010, 32'h0000_9000, 32'h0,        0, 0, 32'h12345678, 30, 0, 32'h0,         4'b0000, 32'h0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("midrst_dbus_addr", dbus_addr, 32'd0);
        chk("midrst_dbus_en", {30'd0, dbus_re, dbus_we}, 32'd0);
        chk("midrst_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (dbus_stall && n < 100) begin
            chk("ready_held_after_reset", {31'd0, req_ready}, 32'd0);
            @(negedge clk);
            n++;
        end
        chk("ready_after_stall_drop", {31'd0, req_ready}, 32'd1);
        send(0, 3'b010, 32'h0000_A004, 32'h0,        0, 0, 32'h0BADF00D, 1,  0, 32'h0BAD_F00D, 4'b0000, 32'h0, 1);

        // Drain
        n = 0;
        while ((exp_q.size() != 0 || exp_bus_q.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("resp_queue_drained", exp_q.size(), 32'd0);
        chk("bus_queue_drained", exp_bus_q.size(), 32'd0);
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
